// File: rtl/serial_shifter_pkg.sv
// Shared types and helpers for the serial shifter: FSM encoding, direction/mode codes,
// and the shift-amount width function.
package shifter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic DIR_RIGHT     = 1'b0;
  localparam logic DIR_LEFT      = 1'b1;
  localparam logic MODE_LOGICAL  = 1'b0;
  localparam logic MODE_ARITH    = 1'b1;

  function automatic int unsigned shamt_width(input int unsigned data_len);
    return $clog2(data_len);
  endfunction

endpackage

// File: rtl/serial_shifter_if.sv
// Request/result handshake bundle for serial_shifter.
// The rotate signal exists only when SERIAL_SHIFTER_ROTATE_EN is defined.
interface serial_shifter_if #(
  parameter int unsigned DATA_LEN = 8
);
  import shifter_pkg::*;

  localparam int unsigned SHAMT_W = shamt_width(DATA_LEN);

  logic                in_valid;
  logic                in_ready;
  logic [DATA_LEN-1:0] din;
  logic [SHAMT_W-1:0]  shamt;
  logic                left;
  logic                arithmetic;
`ifdef SERIAL_SHIFTER_ROTATE_EN
  logic                rotate;
`endif
  logic                out_valid;
  logic                out_ready;
  logic [DATA_LEN-1:0] dout;
  logic                busy;

`ifdef SERIAL_SHIFTER_ROTATE_EN
  modport master (
    output in_valid, din, shamt, left, arithmetic, rotate, out_ready,
    input  in_ready, out_valid, dout, busy
  );
  modport slave (
    input  in_valid, din, shamt, left, arithmetic, rotate, out_ready,
    output in_ready, out_valid, dout, busy
  );
`else
  modport master (
    output in_valid, din, shamt, left, arithmetic, out_ready,
    input  in_ready, out_valid, dout, busy
  );
  modport slave (
    input  in_valid, din, shamt, left, arithmetic, out_ready,
    output in_ready, out_valid, dout, busy
  );
`endif

endinterface

// File: rtl/serial_shifter_shift_step.sv
// Combinational single-position shifter used in the accumulator next-state path.
// rotate wins over arithmetic; arithmetic only matters for right shifts.
module shift_step
  import shifter_pkg::*;
#(
  parameter int unsigned DATA_LEN = 8
) (
  input  logic [DATA_LEN-1:0] acc_i,
  input  logic                left_i,
  input  logic                arithmetic_i,
  input  logic                rotate_i,
  output logic [DATA_LEN-1:0] acc_o
);

  logic fill_right;
  logic fill_left;

  always_comb begin
    fill_left  = rotate_i ? acc_i[DATA_LEN-1] : 1'b0;
    fill_right = rotate_i ? acc_i[0]
                          : ((arithmetic_i == MODE_ARITH) & acc_i[DATA_LEN-1]);
    acc_o      = acc_i;
    if (left_i == DIR_LEFT) begin
      acc_o = {acc_i[DATA_LEN-2:0], fill_left};
    end else begin
      acc_o = {fill_right, acc_i[DATA_LEN-1:1]};
    end
  end

endmodule

// File: rtl/serial_shifter.sv
// Multi-cycle shifter, one bit position per clock, behind valid/ready request and result ports.
// Define SERIAL_SHIFTER_ROTATE_EN to add the rotate request field.
module serial_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned DATA_LEN = 8
) (
  input logic              clk,
  input logic              rst,
  serial_shifter_if.slave  bus
);

  localparam int unsigned SHAMT_W = shamt_width(DATA_LEN);

  state_e              state_q;
  logic [DATA_LEN-1:0] acc_q;
  logic [DATA_LEN-1:0] acc_d;
  logic [SHAMT_W-1:0]  count_q;
  logic                left_q;
  logic                arith_q;
  logic                rot_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                busy_q;
  logic [DATA_LEN-1:0] dout_q;
  logic                accept;

`ifndef SERIAL_SHIFTER_ROTATE_EN
  assign rot_q = 1'b0;
`endif

  assign accept = bus.in_valid && in_ready_q;

  shift_step #(
    .DATA_LEN (DATA_LEN)
  ) u_step (
    .acc_i        (acc_q),
    .left_i       (left_q),
    .arithmetic_i (arith_q),
    .rotate_i     (rot_q),
    .acc_o        (acc_d)
  );

  // Control FSM; dout is captured on entry to DONE so it stays put while waiting for out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      left_q      <= 1'b0;
      arith_q     <= 1'b0;
`ifdef SERIAL_SHIFTER_ROTATE_EN
      rot_q       <= 1'b0;
`endif
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      dout_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_q      <= bus.din;
            count_q    <= bus.shamt;
            left_q     <= bus.left;
            arith_q    <= bus.arithmetic;
`ifdef SERIAL_SHIFTER_ROTATE_EN
            rot_q      <= bus.rotate;
`endif
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (bus.shamt == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              dout_q      <= bus.din;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          acc_q   <= acc_d;
          count_q <= count_q - SHAMT_W'(1);
          if (count_q == SHAMT_W'(1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            dout_q      <= acc_d;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_serial_shifter.sv
// Self-checking bench for serial_shifter: scoreboard of barrel-shifter model results,
// directed cases plus a random regression. Rotate cases run when SERIAL_SHIFTER_ROTATE_EN is defined.
module tb_serial_shifter;
  import shifter_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned SW = shamt_width(DW);

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_shifter_if #(.DATA_LEN(DW)) bus ();

  serial_shifter #(.DATA_LEN(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference barrel shifter
  function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic [SW-1:0] s,
                                          input logic l, input logic a, input logic r);
    logic [DW-1:0] res;
    int unsigned   n;
    n = 32'(s);
    if (r) begin
      if (l) res = DW'((d << n) | (d >> (DW - n)));
      else   res = DW'((d >> n) | (d << (DW - n)));
    end else if (l) begin
      res = DW'(d << n);
    end else if (a) begin
      res = DW'($signed(d) >>> n);
    end else begin
      res = DW'(d >> n);
    end
    return res;
  endfunction

  task automatic do_op(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l,
                       input logic a, input logic r, input int hold);
    int            lat;
    logic          bad;
    logic [DW-1:0] held;
    logic [DW-1:0] exp;
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid   = 1'b1;
    bus.din        = d;
    bus.shamt      = s;
    bus.left       = l;
    bus.arithmetic = a;
`ifdef SERIAL_SHIFTER_ROTATE_EN
    bus.rotate     = r;
`endif
    sb.push_back(model(d, s, l, a, r));
    tick();
    // Scramble operands after accept; they must not affect the in-flight op
    bus.in_valid   = 1'b0;
    bus.din        = ~d;
    bus.shamt      = SW'(s + 1'b1);
    bus.left       = ~l;
    bus.arithmetic = ~a;
`ifdef SERIAL_SHIFTER_ROTATE_EN
    bus.rotate     = ~r;
`endif
    lat = 0;
    bad = 1'b0;
    while (!bus.out_valid && lat < 4 * DW) begin
      if (bus.in_ready || !bus.busy) bad = 1'b1;
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(s));
    check("busy_not_ready", 32'(bad), 32'd0);
    check("out_valid", 32'(bus.out_valid), 32'd1);
    if (hold > 0) begin
      held           = bus.dout;
      bus.in_valid   = 1'b1;
      bus.din        = 8'h3C;
      bus.shamt      = SW'(2);
      bus.left       = 1'b1;
      for (int i = 0; i < hold; i++) begin
        tick();
        if (bus.dout !== held || !bus.out_valid || bus.in_ready) bad = 1'b1;
      end
      bus.in_valid = 1'b0;
      check("hold_stable", 32'(bad), 32'd0);
    end
    check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    check("dout", 32'(bus.dout), 32'(exp));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("ret_out_valid", 32'(bus.out_valid), 32'd0);
    check("ret_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic drop;
    bus.in_valid   = 1'b0;
    bus.din        = '0;
    bus.shamt      = '0;
    bus.left       = 1'b0;
    bus.arithmetic = 1'b0;
`ifdef SERIAL_SHIFTER_ROTATE_EN
    bus.rotate     = 1'b0;
`endif
    bus.out_ready  = 1'b0;
    rst            = 1'b1;
    tick();
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    rst = 1'b0;
    tick();

    do_op(8'h96, SW'(3), 1'b1, 1'b0, 1'b0, 0);
    do_op(8'h96, SW'(3), 1'b0, 1'b1, 1'b0, 0);
    do_op(8'h96, SW'(3), 1'b0, 1'b0, 1'b0, 0);
    do_op(8'h5A, SW'(0), 1'b0, 1'b0, 1'b0, 0);
    do_op(8'h80, SW'(7), 1'b0, 1'b1, 1'b0, 0);
    do_op(8'h96, SW'(3), 1'b1, 1'b0, 1'b0, 5);
    do_op(8'h3C, SW'(2), 1'b1, 1'b0, 1'b0, 0);

    // Reset two steps into a 6-step op: the op is dropped
    bus.in_valid = 1'b1;
    bus.din      = 8'hA5;
    bus.shamt    = SW'(6);
    bus.left     = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    check("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_dout", 32'(bus.dout), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    rst  = 1'b0;
    drop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid) drop = 1'b1;
    end
    check("mid_rst_no_result", 32'(drop), 32'd0);
    do_op(8'h01, SW'(1), 1'b1, 1'b0, 1'b0, 0);

`ifdef SERIAL_SHIFTER_ROTATE_EN
    do_op(8'h96, SW'(3), 1'b1, 1'b0, 1'b1, 0);
    do_op(8'h96, SW'(3), 1'b0, 1'b1, 1'b1, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      do_op(DW'($urandom), SW'($urandom_range(0, DW - 1)), 1'($urandom), 1'($urandom),
            1'b0, int'($urandom_range(0, 2)));
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
